// File: rtl/par_stream_pkg.sv
// ---------------------------------------------------------------------------
// par_stream_pkg
// Shared definitions for the offset-parity link: default widths, the offset
// constant and the expected-parity function. The generator and the checker
// both use expParity so the two ends of the link can never disagree on the
// parity definition.
// ---------------------------------------------------------------------------
package par_stream_pkg;

  localparam int              WIDTH_DEF  = 8;
  localparam logic [7:0]      OFFSET_DEF = 8'h55;
  localparam int              LAT_DEF    = 3;
  localparam int              CNT_W_DEF  = 16;

  // Parity of the low 'width' bits of (data + offset). Operands are passed
  // zero-extended to 64 bits, so the carry out of the byte add lands at bit
  // 'width' and is excluded from the reduction. Supports width up to 64.
  function automatic logic expParity(input logic [63:0] data,
                                     input logic [63:0] offset,
                                     input int          width);
    logic [63:0] sum;
    logic        p;
    sum = data + offset;
    p   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) p = p ^ sum[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/par_delay_line.sv
// ---------------------------------------------------------------------------
// par_delay_line
// Fixed-depth register chain; o_q is i_d delayed by DEPTH clock edges.
// Used by the checker to carry {valid, expected_parity} alongside the link
// latency so each expected bit meets its parity bit from the generator.
//
// Ports:
//   i_clk   clock, all updates on posedge
//   i_rstN  asynchronous active-low reset, clears every stage
//   i_d     value entering stage 0
//   o_q     output of the last stage
// ---------------------------------------------------------------------------
module par_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 2
) (
  input  logic         i_clk,
  input  logic         i_rstN,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/par_stream_checker.sv
// ---------------------------------------------------------------------------
// par_stream_checker
// Receive-side checker for the offset-parity stream. Recomputes the parity
// of (data_in + OFFSET) for every valid byte, delays it LAT cycles so it
// lines up with the generator's serial parity bit, and reports, counts and
// latches mismatches for the link-health status logic.
//
// Ports:
//   clk         clock, all updates on posedge
//   rst         asynchronous active-low reset
//   data_in     byte presented to the generator
//   in_valid    data_in is a real sample this cycle
//   par_in      parity bit arriving from the generator, LAT edges later
//   clr         synchronous clear of err_cnt and sticky_err
//   chk_valid   a comparison result is presented this cycle
//   err         mismatch flag, meaningful only with chk_valid
//   err_cnt     saturating mismatch count
//   sticky_err  set on any mismatch, held until clr or reset
//
// LAT must be at least 1.
// ---------------------------------------------------------------------------
module par_stream_checker
  import par_stream_pkg::*;
#(
  parameter int               WIDTH  = WIDTH_DEF,
  parameter logic [WIDTH-1:0] OFFSET = WIDTH'(OFFSET_DEF),
  parameter int               LAT    = LAT_DEF,
  parameter int               CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  input  logic             par_in,
  input  logic             clr,
  output logic             chk_valid,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sticky_err
);

  logic             w_expPar;
  logic [1:0]       w_slotIn;
  logic [1:0]       w_slotOut;
  logic             w_mismatch;
  logic             r_chkValid;
  logic             r_err;
  logic [CNT_W-1:0] r_errCnt;
  logic             r_sticky;

  // Parity is forced to 0 on empty slots so nothing stale rides the chain.
  assign w_expPar = expParity(64'(data_in), 64'(OFFSET), WIDTH);
  assign w_slotIn = {in_valid, in_valid & w_expPar};

  par_delay_line #(
    .DEPTH (LAT),
    .W     (2)
  ) u_delay (
    .i_clk  (clk),
    .i_rstN (rst),
    .i_d    (w_slotIn),
    .o_q    (w_slotOut)
  );

  // par_in only matters on edges where a valid sample reaches the tap.
  assign w_mismatch = w_slotOut[1] & (w_slotOut[0] ^ par_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chkValid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_chkValid <= w_slotOut[1];
      r_err      <= w_mismatch;
    end
  end

  // A mismatch on the same edge as clr wins: the count restarts at 1
  // instead of 0 so that error is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_errCnt <= '0;
      r_sticky <= 1'b0;
    end else if (w_mismatch) begin
      r_sticky <= 1'b1;
      if (clr) begin
        r_errCnt <= CNT_W'(1);
      end else if (r_errCnt != {CNT_W{1'b1}}) begin
        r_errCnt <= r_errCnt + CNT_W'(1);
      end
    end else if (clr) begin
      r_errCnt <= '0;
      r_sticky <= 1'b0;
    end
  end

  assign chk_valid  = r_chkValid;
  assign err        = r_err;
  assign err_cnt    = r_errCnt;
  assign sticky_err = r_sticky;

endmodule

// File: doc/par_stream_checker.md
Name: par_stream_checker

Overview:
- Receive-side checker for the offset-parity stream produced by the byte-to-parity generator.
- Accepts the same byte stream the generator consumed, plus the generator's 1-bit serial parity output arriving LAT cycles later.
- Recomputes the expected parity of (byte + OFFSET), aligns it with the incoming bit, and flags, counts and latches mismatches.
- Sits at the far end of the link, feeding link-health status to the control/status logic.

Parameters:
- WIDTH, 8, data byte width
- OFFSET, 8'h55, constant the generator adds before the parity reduction
- LAT, 3, cycles from data sample edge to the edge where the matching parity bit is sampled (must be >= 1)
- CNT_W, 16, error counter width

Ports:
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- data_in  input  WIDTH  byte presented to the generator
- in_valid  input  1  data_in is a real sample this cycle
- par_in  input  1  parity bit from the generator's output
- clr  input  1  synchronous clear of err_cnt and sticky_err
- chk_valid  output  1  a comparison result is presented this cycle
- err  output  1  qualified by chk_valid: 1 = mismatch
- err_cnt  output  CNT_W  saturating mismatch count
- sticky_err  output  1  set on any mismatch; held until clr or reset

Behaviour:
- Reset (rst low, asynchronous) clears all pipeline stages, the valid shift register, chk_valid, err, err_cnt and sticky_err to 0.
- Reset release: the first edge with rst high operates normally.
- Expected parity = XOR-reduce of ((data_in + OFFSET) mod 2^WIDTH). The carry out is discarded.
- Pipeline: a sample taken at edge k with in_valid=1 is paired with par_in sampled at edge k+LAT.
- At edge k+LAT, chk_valid <= 1 and err <= (expected != par_in). Both are registered outputs.
- A valid bit travels with each sample through a LAT-deep shift register. in_valid=0 slots yield chk_valid=0 and err=0, and par_in is ignored at those edges.
- Back-to-back in_valid is supported at full rate, one check per cycle, with no stalls.
- err_cnt increments on every edge where a mismatch is registered, and saturates at 2^CNT_W-1 with no wrap.
- sticky_err is set on a mismatch.
- clr on an edge forces err_cnt and sticky_err to 0. If a mismatch is registered on the same edge, the mismatch wins: err_cnt=1, sticky_err=1.
- clr does not flush the pipeline. In-flight samples still produce results.
- Reset mid-stream discards all in-flight samples. No chk_valid is produced for them.

Decomposition:
- Shared package holds WIDTH, OFFSET, LAT defaults and an expected-parity function (add offset, truncate, XOR-reduce). The generator and checker share one definition.
- One sub-module: par_delay_line, a LAT-deep register chain carrying {valid, expected_parity}. It has async active-low reset and a parameterised depth.

Test Plan:
- Reset behaviour: hold rst low with in_valid=1 and par_in toggling, then release -> all outputs stay 0 until the first valid sample reaches edge k+3.
- Matched stream: drive 0x00, 0x01, 0x02, 0xFF, 0xAB back-to-back, with par_in = 0, 0, 1, 1, 0 at edges k+3..k+7 -> chk_valid high for 5 cycles, err=0, err_cnt=0.
- Single-error injection: send 0x02 with par_in=0 at k+3 -> err=1 for one cycle, err_cnt=1, sticky_err=1 and held through later good samples. Also checks 0xAB wrap to 0x00 giving expected parity 0.
- Gaps: alternate in_valid 1/0 with garbage par_in on empty slots -> chk_valid alternates and no errors are counted.
- clr races: assert clr on the same edge as a mismatch -> err_cnt=1, sticky=1. Assert clr alone -> both 0 next cycle while the pipeline continues.
- Saturation: CNT_W=4 with 20 consecutive mismatches -> err_cnt stops at 15. Also assert rst mid-stream -> no chk_valid for in-flight samples.
